// File: rtl/test_binop_pkg.sv
// Shared definitions for the binary-operator CI harness: golden op codes,
// FSM encoding, LFSR constants and the reference operator function.
package test_binop_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

  // Galois right-shift step; a nonzero value never maps to zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

  // Result is taken modulo 2^16 here; callers keep the low W bits.
  function automatic logic [15:0] golden_op(input int op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: r = a * b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/test_binop_seq_lfsr.sv
// 32-bit Galois LFSR with synchronous seed load; shared by CI harnesses
// that need a cheap pseudo-random operand stream.
module test_lfsr32
  import test_binop_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] value,
  output logic [31:0] value_next
);

  logic [31:0] value_q;
  logic [31:0] value_d;

  assign value_next = lfsr_step(value_q);
  assign value      = value_q;

  always_comb begin
    value_d = value_q;
    if (advance) value_d = value_next;
  end

  always_ff @(posedge clock) begin
    if (reset) value_q <= seed;
    else       value_q <= value_d;
  end

endmodule

// File: rtl/test_binop_seq.sv
// Stimulus/check harness for a two-operand arithmetic DUT: one directed vector,
// then LFSR vectors, each checked LATENCY cycles later. Option: TEST_BINOP_STOP_ON_FAIL_EN.
module test_binop_seq
  import test_binop_pkg::*;
#(
  parameter int          W       = 8,
  parameter int          OP      = OP_SUB,
  parameter int          NVEC    = 16,
  parameter int          LATENCY = 0,
  parameter int          A0      = 9,
  parameter int          B0      = 3,
  parameter logic [31:0] SEED    = DEFAULT_SEED
) (
  input  logic         clock,
  input  logic         reset,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic [W-1:0] y,
  output logic         fail,
  output logic         finish,
  output logic [15:0]  err_count
);

  localparam int             VW       = (NVEC > 1) ? $clog2(NVEC) : 1;
  localparam logic [VW-1:0]  LAST_VEC = VW'(NVEC - 1);
  localparam logic [7:0]     CHECK_AT = 8'(LATENCY);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           fail_q, fail_d;
  logic           finish_q, finish_d;
  logic [15:0]    err_q, err_d;
  logic [VW-1:0]  vec_q, vec_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [31:0]    lfsr_value;
  logic [31:0]    lfsr_next;
  logic           advance;
  logic [15:0]    exp_full;
  logic [W-1:0]   exp_val;
  logic           check;
  logic           mismatch;
  logic           stop;

  test_lfsr32 u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .advance    (advance),
    .seed       (SEED),
    .value      (lfsr_value),
    .value_next (lfsr_next)
  );

  // Operands are held for the whole vector, so the expectation can be
  // formed straight from the operand registers.
  assign exp_full = golden_op(OP, 16'(a_q), 16'(b_q));
  assign exp_val  = exp_full[W-1:0];
  assign check    = (state_q == ST_RUN) && (cnt_q == CHECK_AT);
  // 4-state compare so an X/Z result is never accepted.
  assign mismatch = check && (y !== exp_val);
`ifdef TEST_BINOP_STOP_ON_FAIL_EN
  assign stop     = (vec_q == LAST_VEC) || mismatch;
`else
  assign stop     = (vec_q == LAST_VEC);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RUN;
      a_q      <= W'(A0);
      b_q      <= W'(B0);
      fail_q   <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 16'h0;
      vec_q    <= '0;
      cnt_q    <= 8'h0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fail_q   <= fail_d;
      finish_q <= finish_d;
      err_q    <= err_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (check && stop) state_d = ST_DONE;
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    fail_d   = fail_q;
    finish_d = finish_q;
    err_d    = err_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    advance  = 1'b0;
    if (state_q == ST_RUN) begin
      if (mismatch) begin
        fail_d = 1'b1;
        if (err_q != 16'hFFFF) err_d = err_q + 16'h1;
      end
      if (!check) begin
        cnt_d = cnt_q + 8'h1;
      end else if (stop) begin
        finish_d = 1'b1;
      end else begin
        // Next vector starts on the very next cycle: no bubble.
        vec_d   = vec_q + 1'b1;
        cnt_d   = 8'h0;
        advance = 1'b1;
        a_d     = lfsr_next[W-1:0];
        b_d     = lfsr_next[31:32-W];
      end
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign fail      = fail_q;
  assign finish    = finish_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_test_binop_seq.sv
// Bench for test_binop_seq: four harness instances with differing parameters,
// each wired to a bench-side DUT whose behaviour (correct/wrong op/stuck-at-0) is selectable.
module tb_test_binop_seq;

  localparam int          N_INST = 4;
  localparam int          P_W    [N_INST] = '{8, 8, 8, 5};
  localparam int          P_OP   [N_INST] = '{1, 1, 0, 2};
  localparam int          P_NVEC [N_INST] = '{1, 6, 16, 8};
  localparam int          P_LAT  [N_INST] = '{0, 0, 2, 1};
  localparam int          P_A0   [N_INST] = '{9, 3, 9, 7};
  localparam int          P_B0   [N_INST] = '{3, 9, 3, 6};
  localparam logic [31:0] P_SEED [N_INST] = '{32'hACE10001, 32'hACE10001, 32'hACE10001, 32'h12345679};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rst_sampled = 1'b0;
  int   mode [N_INST];
  int   phase = 0;
  int   checks = 0;
  int   errors = 0;
  int   t = 0;
  bit   armed = 1'b0;

  logic [15:0] a_mon   [N_INST];
  logic [15:0] b_mon   [N_INST];
  logic [15:0] err_mon [N_INST];
  logic        fail_mon[N_INST];
  logic        fin_mon [N_INST];

  int tab_a   [N_INST][16];
  int tab_b   [N_INST][16];
  bit tab_bad [N_INST][16];

  always #5 clock = ~clock;
  always @(posedge clock) rst_sampled <= reset;

  function automatic int golden(input int op, input int a, input int b, input int w);
    longint m = longint'(1) << w;
    longint r;
    case (op)
      0:       r = longint'(a) + b;
      1:       r = longint'(a) - b + m;
      default: r = longint'(a) * b;
    endcase
    return int'(r % m);
  endfunction

  // Behaviour of the bench-side DUT: 0 correct, 1 always adds, 2 stuck at 0.
  function automatic int dut_fn(input int md, input int op, input int a, input int b, input int w);
    if (md == 0) return golden(op, a, b, w);
    if (md == 1) return golden(0, a, b, w);
    return 0;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
    localparam int W = P_W[gi];
    logic [W-1:0] a_w, b_w, y_w, now_w;
    logic         fail_w, fin_w;
    logic [15:0]  err_w;
    logic [W-1:0] pipe [4];

    test_binop_seq #(
      .W(W), .OP(P_OP[gi]), .NVEC(P_NVEC[gi]), .LATENCY(P_LAT[gi]),
      .A0(P_A0[gi]), .B0(P_B0[gi]), .SEED(P_SEED[gi])
    ) u_dut (
      .clock(clock), .reset(reset), .a(a_w), .b(b_w), .y(y_w),
      .fail(fail_w), .finish(fin_w), .err_count(err_w)
    );

    assign now_w = W'(dut_fn(mode[gi], P_OP[gi], int'(a_w), int'(b_w), W));
    always @(posedge clock) begin
      pipe[0] <= now_w;
      for (int p = 1; p < 4; p++) pipe[p] <= pipe[p-1];
    end
    if (P_LAT[gi] == 0) begin : g_comb
      assign y_w = now_w;
    end else begin : g_pipe
      assign y_w = pipe[P_LAT[gi]-1];
    end

    assign a_mon[gi]    = 16'(a_w);
    assign b_mon[gi]    = 16'(b_w);
    assign err_mon[gi]  = err_w;
    assign fail_mon[gi] = fail_w;
    assign fin_mon[gi]  = fin_w;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (phase %0d, t=%0d)", name, act, exp, phase, t);
    end
  endtask

  // Operand sequence and pass/fail verdict of every vector for instance i.
  task automatic build_tables(input int i);
    logic [31:0] s = P_SEED[i];
    int w = P_W[i];
    for (int k = 0; k < P_NVEC[i]; k++) begin
      if (k == 0) begin
        tab_a[i][k] = P_A0[i] % (1 << w);
        tab_b[i][k] = P_B0[i] % (1 << w);
      end else begin
        s = lfsr_step(s);
        tab_a[i][k] = int'(s & ((32'h1 << w) - 32'h1));
        tab_b[i][k] = int'(s >> (32 - w));
      end
      tab_bad[i][k] = dut_fn(mode[i], P_OP[i], tab_a[i][k], tab_b[i][k], w)
                      != golden(P_OP[i], tab_a[i][k], tab_b[i][k], w);
    end
  endtask

  task automatic check_inst(input int i);
    int l1 = P_LAT[i] + 1;
    int last = P_NVEC[i] - 1;
    int k, nchk, errs, fin;
`ifdef TEST_BINOP_STOP_ON_FAIL_EN
    for (int j = P_NVEC[i] - 1; j >= 0; j--)
      if (tab_bad[i][j]) last = j;
`endif
    if (t < (last + 1) * l1) begin
      k = t / l1; nchk = k; fin = 0;
    end else begin
      k = last; nchk = last + 1; fin = 1;
    end
    errs = 0;
    for (int j = 0; j < nchk; j++) errs += int'(tab_bad[i][j]);
    chk($sformatf("u%0d.a", i), int'(a_mon[i]), tab_a[i][k]);
    chk($sformatf("u%0d.b", i), int'(b_mon[i]), tab_b[i][k]);
    chk($sformatf("u%0d.finish", i), int'(fin_mon[i]), fin);
    chk($sformatf("u%0d.err_count", i), int'(err_mon[i]), errs);
    chk($sformatf("u%0d.fail", i), int'(fail_mon[i]), int'(errs > 0));
  endtask

  // Hand-computed expectations that pin the model.
  task automatic literal_checks();
    if (phase == 1 && t == 1) begin
      chk("lit sub9-3 finish", int'(fin_mon[0]), 1);
      chk("lit sub9-3 fail", int'(fail_mon[0]), 0);
      chk("lit sub9-3 err", int'(err_mon[0]), 0);
      chk("lit sub3-9 fail", int'(fail_mon[1]), 0);
      chk("lit lfsr1 a", int'(a_mon[1]), 8'h03);
      chk("lit lfsr1 b", int'(b_mon[1]), 8'hD6);
    end
    if (phase == 1 && t == 0) begin
      chk("lit mul a0", int'(a_mon[3]), 7);
      chk("lit mul b0", int'(b_mon[3]), 6);
    end
    if (phase == 1 && t == 3) begin
      chk("lit lat2 vec1 a", int'(a_mon[2]), 8'h03);
      chk("lit lat2 vec1 b", int'(b_mon[2]), 8'hD6);
    end
    if (phase == 1 && t == 47) chk("lit lat2 finish@47", int'(fin_mon[2]), 0);
    if (phase == 1 && t == 48) begin
      chk("lit lat2 finish@48", int'(fin_mon[2]), 1);
      chk("lit lat2 fail@48", int'(fail_mon[2]), 0);
    end
    if (phase == 2 && t == 1) begin
      chk("lit bad sub finish", int'(fin_mon[0]), 1);
      chk("lit bad sub fail", int'(fail_mon[0]), 1);
      chk("lit bad sub err", int'(err_mon[0]), 1);
    end
    if (phase == 2 && t == 3) begin
      chk("lit stuck0 err@3", int'(err_mon[2]), 1);
`ifdef TEST_BINOP_STOP_ON_FAIL_EN
      chk("lit stuck0 finish@3", int'(fin_mon[2]), 1);
`else
      chk("lit stuck0 finish@3", int'(fin_mon[2]), 0);
`endif
    end
    if (phase == 4 && t == 0) begin
      chk("lit restart a", int'(a_mon[2]), 9);
      chk("lit restart b", int'(b_mon[2]), 3);
      chk("lit restart err", int'(err_mon[2]), 0);
      chk("lit restart fail", int'(fail_mon[2]), 0);
      chk("lit restart finish", int'(fin_mon[2]), 0);
    end
    if (phase == 4 && t == 48) begin
      chk("lit rerun finish", int'(fin_mon[2]), 1);
      chk("lit rerun fail", int'(fail_mon[2]), 0);
    end
  endtask

  // Single compare process: t counts edges since reset release.
  always begin
    @(negedge clock);
    #1;
    if (rst_sampled) begin
      t = 0;
      armed = 1'b1;
    end else begin
      t++;
    end
    if (armed) begin
      for (int i = 0; i < N_INST; i++) begin
        if (t == 0) build_tables(i);
        check_inst(i);
      end
      literal_checks();
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N_INST; i++) mode[i] = 0;
    repeat (3) @(negedge clock);

    phase = 1;
    pulse_reset();
    repeat (60) @(negedge clock);

    phase = 2;
    mode[0] = 1;
    mode[2] = 2;
    mode[3] = 1;
    pulse_reset();
    repeat (60) @(negedge clock);

    // Restart with faults still present, then abort inside vector 5 of u2.
    phase = 3;
    pulse_reset();
    repeat (16) @(negedge clock);

    phase = 4;
    for (int i = 0; i < N_INST; i++) mode[i] = 0;
    pulse_reset();
    repeat (60) @(negedge clock);

    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
